// File: rtl/mmio_responder.sv
// mmio_responder: MMIO register window for display, LEDs, debounced switches, button events and timer.
// Define MMIO_IRQ_EN to add IRQ_MASK (offset 5) and a masked button-event interrupt on irq.

module mmio_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);
    logic        s1, s2;
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any agreement with the debounced value restarts the stability window
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

module mmio_responder #(
    parameter logic [9:0]  BASE_ADDR       = 10'h3F0,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          NUM_SW          = 10,
    parameter int          NUM_BTN         = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               write_en,
    input  logic [9:0]         addr,
    input  logic [15:0]        wr_data,
    output logic [15:0]        rd_data,
    output logic               hit,
    input  logic [NUM_SW-1:0]  switches,
    input  logic [NUM_BTN-1:0] buttons,
    output logic [15:0]        display_value,
    output logic [4:0]         led_value,
    output logic               irq
);
    localparam logic [2:0] OFF_DISPLAY = 3'd0;
    localparam logic [2:0] OFF_LED     = 3'd1;
    localparam logic [2:0] OFF_SWITCH  = 3'd2;
    localparam logic [2:0] OFF_BTN_EVT = 3'd3;
    localparam logic [2:0] OFF_TIMER   = 3'd4;
    localparam logic [2:0] OFF_IRQ_MSK = 3'd5;

    logic [9:0]         off;
    logic               in_win, wr_hit;
    logic [NUM_SW-1:0]  sw_deb;
    logic [NUM_BTN-1:0] btn_deb, btn_deb_q, btn_rise, btn_evt, btn_clr;
    logic [15:0]        timer, rd_next;
`ifdef MMIO_IRQ_EN
    logic [NUM_BTN-1:0] irq_mask;
`endif

    // Offset arithmetic keeps the window correct for unaligned BASE_ADDR
    assign off    = addr - BASE_ADDR;
    assign in_win = (off[9:3] == 7'd0);
    assign wr_hit = write_en & in_win;

    mmio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db [NUM_SW-1:0] (
        .clk   (clk),
        .reset (reset),
        .raw   (switches),
        .deb   (sw_deb)
    );

    mmio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db [NUM_BTN-1:0] (
        .clk   (clk),
        .reset (reset),
        .raw   (buttons),
        .deb   (btn_deb)
    );

    assign btn_rise = btn_deb & ~btn_deb_q;
    assign btn_clr  = (wr_hit && off[2:0] == OFF_BTN_EVT) ? wr_data[NUM_BTN-1:0] : '0;

    always_comb begin
        rd_next = '0;
        if (in_win) begin
            case (off[2:0])
                OFF_DISPLAY: rd_next = display_value;
                OFF_LED:     rd_next[4:0] = led_value;
                OFF_SWITCH:  rd_next[NUM_SW-1:0] = sw_deb;
                OFF_BTN_EVT: rd_next[NUM_BTN-1:0] = btn_evt;
                OFF_TIMER:   rd_next = timer;
`ifdef MMIO_IRQ_EN
                OFF_IRQ_MSK: rd_next[NUM_BTN-1:0] = irq_mask;
`endif
                default:     rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display_value <= '0;
            led_value     <= '0;
            btn_evt       <= '0;
            btn_deb_q     <= '0;
            timer         <= '0;
            rd_data       <= '0;
            hit           <= 1'b0;
        end else begin
            rd_data   <= rd_next;
            hit       <= in_win;
            btn_deb_q <= btn_deb;
            // Set wins over a same-cycle W1C
            btn_evt   <= (btn_evt & ~btn_clr) | btn_rise;
            timer     <= (wr_hit && off[2:0] == OFF_TIMER) ? wr_data : timer + 16'd1;
            if (wr_hit) begin
                case (off[2:0])
                    OFF_DISPLAY: display_value <= wr_data;
                    OFF_LED:     led_value     <= wr_data[4:0];
                    default:     ;
                endcase
            end
        end
    end

`ifdef MMIO_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_hit && off[2:0] == OFF_IRQ_MSK) irq_mask <= wr_data[NUM_BTN-1:0];
            irq <= |(btn_evt & irq_mask);
        end
    end
`else
    assign irq = 1'b0;
`endif
endmodule
